// File: rtl/mcp_pkg.sv
// -----------------------------------------------------------------------------
// mcp_pkg
// Shared definitions for the B side of the multi-cycle-path (MCP) handshake.
//   state_t   : B-side FSM encoding (WAIT=0, READY=1)
//   DW_DEF    : default payload width
//   NREQ_DEF  : default number of B-domain consumers
//   TMO_DEF   : default idle-timeout count (used only with MCP_B_ARB_TIMEOUT_EN)
// -----------------------------------------------------------------------------
package mcp_pkg;

  typedef enum logic {
    WAIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int DW_DEF   = 8;
  localparam int NREQ_DEF = 4;
  localparam int TMO_DEF  = 16;

endpackage

// File: rtl/mcp_tgl_sync.sv
// -----------------------------------------------------------------------------
// mcp_tgl_sync
// Brings an A-domain request toggle into clk_b through a two-flop synchroniser
// and converts every level change into a one-cycle pulse using a history flop.
// Ports:
//   clk_b  in   B-domain clock
//   rstn_b in   asynchronous active-low reset
//   tgl    in   toggle from the A domain (asynchronous to clk_b)
//   pulse  out  one-cycle pulse per toggle edge (s2 XOR s3)
// -----------------------------------------------------------------------------
module mcp_tgl_sync (
  input  logic clk_b,
  input  logic rstn_b,
  input  logic tgl,
  output logic pulse
);

  logic s1_reg;
  logic s2_reg;
  logic s3_reg;

  always_ff @(posedge clk_b or negedge rstn_b) begin
    if (!rstn_b) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= tgl;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  // s2 is the first metastability-safe copy; s3 remembers the previous level.
  assign pulse = s2_reg ^ s3_reg;

endmodule

// File: rtl/mcp_b_arb.sv
// -----------------------------------------------------------------------------
// mcp_b_arb
// B-domain receiver of a toggle-based MCP handshake. A payload announced by an
// A-side toggle is captured and held, then handed to exactly one of NREQ
// consumers chosen round-robin. The grant is a one-cycle load strobe and
// toggles the acknowledge back to the A domain.
//
// Optional feature macro: MCP_B_ARB_TIMEOUT_EN
//   When defined, a payload left unclaimed (READY with req==0) for TMO cycles
//   is discarded: drop pulses, the ack toggles and the FSM returns to WAIT.
//   When undefined, drop is tied low and READY persists until a grant.
//
// Ports:
//   clk_b      in   B-domain clock
//   rstn_b     in   asynchronous active-low reset
//   a_req_tgl  in   request toggle from the A domain
//   a_data     in   [DW]   payload, stable while a request is outstanding
//   b_ack_tgl  out  acknowledge toggle to the A domain (direct flop output)
//   req        in   [NREQ] per-consumer load requests
//   gnt        out  [NREQ] one-hot grant (one-cycle load)
//   bvalid     out  held payload available
//   bdata      out  [DW]   held payload
//   err        out  sticky protocol-violation flag
//   drop       out  one-cycle timeout-discard pulse
// -----------------------------------------------------------------------------
module mcp_b_arb
  import mcp_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int TMO  = TMO_DEF
) (
  input  logic            clk_b,
  input  logic            rstn_b,
  input  logic            a_req_tgl,
  input  logic [DW-1:0]   a_data,
  output logic            b_ack_tgl,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            bvalid,
  output logic [DW-1:0]   bdata,
  output logic            err,
  output logic            drop
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic            b_en;
  state_t          state_reg;
  state_t          state_next;
  logic [DW-1:0]   bdata_reg;
  logic            ack_reg;
  logic            ack_next;
  logic            err_reg;
  logic            err_next;
  // ptr_reg holds the index with the highest priority for the next grant.
  logic [PW-1:0]   ptr_reg;
  logic [PW-1:0]   ptr_next;
  logic [NREQ-1:0] gnt_c;
  logic [PW-1:0]   gnt_idx;
  logic            capture;

`ifdef MCP_B_ARB_TIMEOUT_EN
  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
  logic [TW-1:0]   cnt_reg;
  logic [TW-1:0]   cnt_next;
  logic            drop_reg;
  logic            drop_next;
`endif

  mcp_tgl_sync u_sync (
    .clk_b  (clk_b),
    .rstn_b (rstn_b),
    .tgl    (a_req_tgl),
    .pulse  (b_en)
  );

  // Round-robin pick: scan from ptr_reg upward with wrap, first set request wins.
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    gnt_c   = '0;
    gnt_idx = ptr_reg;
    found   = 1'b0;
    idx     = '0;
    if (state_reg == READY) begin
      for (int i = 0; i < NREQ; i++) begin
        idx = PW'((int'(ptr_reg) + i) % NREQ);
        if (!found && req[idx]) begin
          gnt_c[idx] = 1'b1;
          gnt_idx    = idx;
          found      = 1'b1;
        end
      end
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_next = state_reg;
    ack_next   = ack_reg;
    err_next   = err_reg;
    ptr_next   = ptr_reg;
    capture    = 1'b0;
`ifdef MCP_B_ARB_TIMEOUT_EN
    cnt_next   = '0;
    drop_next  = 1'b0;
`endif
    case (state_reg)
      WAIT: begin
        if (b_en) begin
          capture    = 1'b1;
          state_next = READY;
        end
      end
      READY: begin
        // A new toggle before the held word was consumed is a protocol
        // violation; it is flagged and otherwise ignored.
        if (b_en) begin
          err_next = 1'b1;
        end
        if (req != '0) begin
          state_next = WAIT;
          ack_next   = ~ack_reg;
          ptr_next   = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
        end
`ifdef MCP_B_ARB_TIMEOUT_EN
        else if (cnt_reg == TW'(TMO - 1)) begin
          state_next = WAIT;
          ack_next   = ~ack_reg;
          drop_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + TW'(1);
        end
`endif
      end
      default: state_next = WAIT;
    endcase
  end

  always_ff @(posedge clk_b or negedge rstn_b) begin
    if (!rstn_b) begin
      state_reg <= WAIT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk_b or negedge rstn_b) begin
    if (!rstn_b) begin
      bdata_reg <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      ptr_reg   <= '0;
`ifdef MCP_B_ARB_TIMEOUT_EN
      cnt_reg   <= '0;
      drop_reg  <= 1'b0;
`endif
    end else begin
      if (capture) begin
        bdata_reg <= a_data;
      end
      ack_reg <= ack_next;
      err_reg <= err_next;
      ptr_reg <= ptr_next;
`ifdef MCP_B_ARB_TIMEOUT_EN
      cnt_reg  <= cnt_next;
      drop_reg <= drop_next;
`endif
    end
  end

  assign bvalid    = (state_reg == READY);
  assign bdata     = bdata_reg;
  assign gnt       = gnt_c;
  assign b_ack_tgl = ack_reg;
  assign err       = err_reg;
`ifdef MCP_B_ARB_TIMEOUT_EN
  assign drop      = drop_reg;
`else
  assign drop      = 1'b0;
`endif

endmodule

// File: tb/tb_mcp_b_arb.sv
// -----------------------------------------------------------------------------
// tb_mcp_b_arb
// Self-checking bench for mcp_b_arb (DW=8, NREQ=4, TMO=16). A transaction-level
// reference model tracks the expected ack level, sticky error, held payload and
// the round-robin priority start index.
// -----------------------------------------------------------------------------
module tb_mcp_b_arb;

  localparam int DW   = 8;
  localparam int NREQ = 4;
  localparam int TMO  = 16;

  logic            clk_b;
  logic            rstn_b;
  logic            a_req_tgl;
  logic [DW-1:0]   a_data;
  logic            b_ack_tgl;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            bvalid;
  logic [DW-1:0]   bdata;
  logic            err;
  logic            drop;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic          exp_ack;
  logic          exp_err;
  logic [DW-1:0] exp_data;
  int            rr_next;

  mcp_b_arb #(.DW(DW), .NREQ(NREQ), .TMO(TMO)) dut (
    .clk_b     (clk_b),
    .rstn_b    (rstn_b),
    .a_req_tgl (a_req_tgl),
    .a_data    (a_data),
    .b_ack_tgl (b_ack_tgl),
    .req       (req),
    .gnt       (gnt),
    .bvalid    (bvalid),
    .bdata     (bdata),
    .err       (err),
    .drop      (drop)
  );

  initial clk_b = 1'b0;
  always #5 clk_b = ~clk_b;

  // First requester at or after 'start' (wrapping) wins.
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] r, input int start);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (start + k) % NREQ;
      if (r[j]) return NREQ'(1) << j;
    end
    return '0;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] g);
    for (int k = 0; k < NREQ; k++) if (g[k]) return k;
    return 0;
  endfunction

  task automatic apply_reset();
    rstn_b    = 1'b0;
    a_req_tgl = 1'b0;
    req       = '0;
    a_data    = '0;
    repeat (2) @(posedge clk_b);
    @(negedge clk_b);
    rstn_b   = 1'b1;
    exp_ack  = 1'b0;
    exp_err  = 1'b0;
    exp_data = '0;
    rr_next  = 0;
  endtask

  // Toggle the request with payload d and check the two-edge latency.
  task automatic do_capture(input logic [DW-1:0] d, input string name);
    @(posedge clk_b); #1;
    a_data    = d;
    a_req_tgl = ~a_req_tgl;
    @(posedge clk_b);
    @(posedge clk_b);
    @(negedge clk_b);
    vectors++;
    if (bvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_early: bvalid=%b expected 0", name, bvalid);
    end
    @(posedge clk_b);
    @(negedge clk_b);
    exp_data = d;
    vectors++;
    if (bvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_valid: bvalid=%b expected 1", name, bvalid);
    end
    vectors++;
    if (bdata !== exp_data) begin
      miscompares++;
      $display("FAIL %s_data: bdata=%h expected %h", name, bdata, exp_data);
    end
    vectors++;
    if (b_ack_tgl !== exp_ack) begin
      miscompares++;
      $display("FAIL %s_ack: b_ack_tgl=%b expected %b", name, b_ack_tgl, exp_ack);
    end
  endtask

  // Present r for one cycle from READY and check grant, ack and return to WAIT.
  task automatic do_grant(input logic [NREQ-1:0] r, input string name, output logic [NREQ-1:0] seen);
    logic [NREQ-1:0] exp_g;
    exp_g = rr_pick(r, rr_next);
    @(posedge clk_b); #1;
    req = r;
    @(negedge clk_b);
    seen = gnt;
    vectors++;
    if (gnt !== exp_g) begin
      miscompares++;
      $display("FAIL %s_gnt: gnt=%b expected %b (req=%b)", name, gnt, exp_g, r);
    end
    @(posedge clk_b); #1;
    req     = '0;
    exp_ack = ~exp_ack;
    rr_next = (onehot_idx(exp_g) + 1) % NREQ;
    @(negedge clk_b);
    vectors++;
    if (b_ack_tgl !== exp_ack) begin
      miscompares++;
      $display("FAIL %s_ack: b_ack_tgl=%b expected %b", name, b_ack_tgl, exp_ack);
    end
    vectors++;
    if (bvalid !== 1'b0 || gnt !== '0) begin
      miscompares++;
      $display("FAIL %s_idle: bvalid=%b gnt=%b expected 0/0000", name, bvalid, gnt);
    end
    vectors++;
    if (bdata !== exp_data || err !== exp_err) begin
      miscompares++;
      $display("FAIL %s_hold: bdata=%h err=%b expected %h/%b", name, bdata, err, exp_data, exp_err);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk_b);
    vectors++;
    if ({bvalid, b_ack_tgl, err, drop} !== 4'b0000 || bdata !== '0 || gnt !== '0) begin
      miscompares++;
      $display("FAIL reset_state: bvalid=%b ack=%b err=%b drop=%b bdata=%h gnt=%b expected all 0",
               bvalid, b_ack_tgl, err, drop, bdata, gnt);
    end
  endtask

  task automatic test_capture();
    do_capture(8'hA5, "capture");
  endtask

  task automatic test_grant();
    logic [NREQ-1:0] seen;
    do_grant(4'b0110, "grant", seen);
    vectors++;
    if (seen !== 4'b0010) begin
      miscompares++;
      $display("FAIL grant_first: gnt=%b expected 0010", seen);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] seen;
    logic [NREQ-1:0] want [5];
    want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    for (int n = 0; n < 5; n++) begin
      do_capture(DW'($urandom), "rr_cap");
      do_grant(4'b1111, "rr", seen);
      vectors++;
      if (seen !== want[n]) begin
        miscompares++;
        $display("FAIL rr_seq%0d: gnt=%b expected %b", n, seen, want[n]);
      end
    end
  endtask

  task automatic test_err();
    logic [NREQ-1:0] seen;
    do_capture(8'h3C, "err_cap");
    @(posedge clk_b); #1;
    a_data    = 8'hC3;
    a_req_tgl = ~a_req_tgl;
    repeat (3) @(posedge clk_b);
    @(negedge clk_b);
    exp_err = 1'b1;
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_flag: err=%b expected 1", err);
    end
    vectors++;
    if (bvalid !== 1'b1 || bdata !== 8'h3C) begin
      miscompares++;
      $display("FAIL err_hold: bvalid=%b bdata=%h expected 1/3c", bvalid, bdata);
    end
    do_grant(NREQ'($urandom_range(1, 15)), "err_gnt", seen);
  endtask

  task automatic test_random();
    logic [NREQ-1:0] seen;
    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk_b);
      do_capture(DW'($urandom), "rnd_cap");
      repeat ($urandom_range(0, 5)) @(posedge clk_b);
      do_grant(NREQ'($urandom_range(1, 15)), "rnd", seen);
    end
  endtask

  task automatic test_async_reset();
    logic [NREQ-1:0] seen;
    if (exp_ack == 1'b0) begin
      do_capture(8'h11, "ar_pre");
      do_grant(4'b0001, "ar_pre", seen);
    end
    do_capture(8'h5A, "ar_cap");
    @(posedge clk_b); #1;
    req = 4'b1000;
    #2;
    rstn_b    = 1'b0;
    a_req_tgl = 1'b0;
    #1;
    vectors++;
    if (bvalid !== 1'b0 || gnt !== '0 || b_ack_tgl !== 1'b0 || bdata !== '0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: bvalid=%b gnt=%b ack=%b bdata=%h err=%b expected all 0",
               bvalid, gnt, b_ack_tgl, bdata, err);
    end
    req = '0;
    @(negedge clk_b);
    rstn_b   = 1'b1;
    exp_ack  = 1'b0;
    exp_err  = 1'b0;
    exp_data = '0;
    rr_next  = 0;
    do_capture(8'h77, "post_rst");
    do_grant(4'b1010, "post_rst", seen);
  endtask

`ifdef MCP_B_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_capture(8'h99, "tmo_cap");
    repeat (TMO - 1) @(posedge clk_b);
    @(negedge clk_b);
    vectors++;
    if (bvalid !== 1'b1 || drop !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_before: bvalid=%b drop=%b expected 1/0", bvalid, drop);
    end
    @(posedge clk_b);
    @(negedge clk_b);
    exp_ack = ~exp_ack;
    vectors++;
    if (drop !== 1'b1 || bvalid !== 1'b0 || b_ack_tgl !== exp_ack) begin
      miscompares++;
      $display("FAIL tmo_fire: drop=%b bvalid=%b ack=%b expected 1/0/%b", drop, bvalid, b_ack_tgl, exp_ack);
    end
    @(posedge clk_b);
    @(negedge clk_b);
    vectors++;
    if (drop !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_pulse: drop=%b expected 0", drop);
    end
  endtask
`else
  task automatic test_timeout();
    logic [NREQ-1:0] seen;
    do_capture(8'h99, "hold_cap");
    repeat (TMO + 8) @(posedge clk_b);
    @(negedge clk_b);
    vectors++;
    if (bvalid !== 1'b1 || drop !== 1'b0 || b_ack_tgl !== exp_ack) begin
      miscompares++;
      $display("FAIL hold_persist: bvalid=%b drop=%b ack=%b expected 1/0/%b", bvalid, drop, b_ack_tgl, exp_ack);
    end
    do_grant(4'b0100, "hold_gnt", seen);
  endtask
`endif

  initial begin
    test_reset();
    test_capture();
    test_grant();
    test_round_robin();
    test_err();
    test_random();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
